// File: rtl/token_fifo.sv
// Elastic FTk/BTk token FIFO with first-word-fall-through output, registered nack
// toward the producer and a sticky overflow flag.
package token_fifo_pkg;
  typedef struct packed {
    logic       v;
    logic       a;
    logic       c;
    logic       r;
    logic [3:0] i;
    logic [7:0] d;
  } FTk_t;

  typedef struct packed {
    logic n;
    logic t;
    logic v;
    logic c;
  } BTk_t;
endpackage

module token_fifo
  import token_fifo_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int SLACK = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       I_En,
  input  FTk_t                       I_FTk,
  input  BTk_t                       I_BTk,
  output FTk_t                       O_FTk,
  output BTk_t                       O_BTk,
  output logic [$clog2(DEPTH):0]     O_Count,
  output logic                       O_Full,
  output logic                       O_Empty,
  output logic                       O_Ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  // Nack threshold leaves SLACK free entries for words already in flight.
  localparam logic [CW-1:0] NACK_LVL = CW'(DEPTH - SLACK);

  typedef struct packed {
    logic       a;
    logic       c;
    logic       r;
    logic [3:0] i;
    logic [7:0] d;
  } word_t;

  word_t         mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          full;
  logic          empty;
  logic          pop;
  logic          push;
  logic          ovf;
  logic          nack;
  logic          bt_t;
  logic          bt_v;
  logic          bt_c;

  assign full       = (count == DEPTH_C);
  assign empty      = (count == '0);
  assign pop        = I_En & ~empty & ~I_BTk.n;
  assign push       = I_En & I_FTk.v & (~full | pop);
  assign count_next = count + CW'(push) - CW'(pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
      nack  <= 1'b0;
      bt_t  <= 1'b0;
      bt_v  <= 1'b0;
      bt_c  <= 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        mem[k] <= '0;
      end
    end else begin
      if (push) begin
        mem[wptr] <= '{a: I_FTk.a, c: I_FTk.c, r: I_FTk.r, i: I_FTk.i, d: I_FTk.d};
        wptr      <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      count <= count_next;
      // A word arriving while full with no pop is dropped; only the flag records it.
      if (I_En & I_FTk.v & full & ~pop) begin
        ovf <= 1'b1;
      end
      nack <= ~I_En | (count_next >= NACK_LVL);
      bt_t <= I_BTk.t;
      bt_v <= I_BTk.v;
      bt_c <= I_BTk.c;
    end
  end

  always_comb begin
    O_FTk   = '0;
    O_FTk.v = I_En & ~empty;
    O_FTk.a = mem[rptr].a;
    O_FTk.c = mem[rptr].c;
    O_FTk.r = mem[rptr].r;
    O_FTk.i = mem[rptr].i;
    O_FTk.d = mem[rptr].d;
    O_BTk   = '0;
    O_BTk.n = nack;
    O_BTk.t = bt_t;
    O_BTk.v = bt_v;
    O_BTk.c = bt_c;
  end

  assign O_Count = count;
  assign O_Full  = full;
  assign O_Empty = empty;
  assign O_Ovf   = ovf;
endmodule
